// File: rtl/matvec3_pkg.sv
// matvec3_pkg: shared widths, default geometry, controller state encoding
// and a counter-width helper for the 3x3 matrix-vector multiplier.
package matvec3_pkg;

  localparam int DATA_W   = 14;
  localparam int ACC_W    = 28;
  localparam int DEF_ROWS = 3;
  localparam int DEF_COLS = 3;

  typedef enum logic [1:0] {
    LOAD_M,
    LOAD_X,
    COMPUTE,
    OUTPUT
  } ctrl_state_t;

  // Width of a counter/address that must hold values 0..n-1 (never 0 bits).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matvec3_ctrl_if.sv
// matvec3_ctrl_if: stream handshakes plus the control/address lines the
// controller drives into the datapath. keep_matrix only exists when
// MATVEC3_CTRL_MREUSE_EN is defined.
interface matvec3_ctrl_if #(
  parameter int ROWS = matvec3_pkg::DEF_ROWS,
  parameter int COLS = matvec3_pkg::DEF_COLS
);
  import matvec3_pkg::*;

  localparam int AM_W = cnt_w(ROWS * COLS);
  localparam int AX_W = cnt_w(COLS);

  logic            input_valid;
  logic            input_ready;
  logic            output_valid;
  logic            output_ready;
  logic            wr_en_m;
  logic [AM_W-1:0] addr_m;
  logic            wr_en_x;
  logic [AX_W-1:0] addr_x;
  logic            clear_acc;
  logic            en_acc;
`ifdef MATVEC3_CTRL_MREUSE_EN
  logic            keep_matrix;
`endif

  // Controller side.
  modport master (
    input  input_valid,
    input  output_ready,
`ifdef MATVEC3_CTRL_MREUSE_EN
    input  keep_matrix,
`endif
    output input_ready,
    output output_valid,
    output wr_en_m,
    output addr_m,
    output wr_en_x,
    output addr_x,
    output clear_acc,
    output en_acc
  );

  // Environment side (upstream source, downstream sink, datapath).
  modport slave (
    output input_valid,
    output output_ready,
`ifdef MATVEC3_CTRL_MREUSE_EN
    output keep_matrix,
`endif
    input  input_ready,
    input  output_valid,
    input  wr_en_m,
    input  addr_m,
    input  wr_en_x,
    input  addr_x,
    input  clear_acc,
    input  en_acc
  );

endinterface

// File: rtl/matvec3_cnt.sv
// matvec3_cnt: modulo-MOD up counter with enable, synchronous clear,
// asynchronous reset and a terminal-count flag (count == MOD-1).
module matvec3_cnt
  import matvec3_pkg::*;
#(
  parameter int  MOD = 3,
  localparam int W   = cnt_w(MOD)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign tc = (count == LAST);

  // Count up on enable, wrapping to 0 after the terminal value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/matvec3_ctrl.sv
// matvec3_ctrl: sequencer for the 3x3 matrix x 3-vector multiplier.
// Loads the matrix (row-major) and vector through a valid/ready stream,
// then runs one multiply-accumulate pass per row and presents each row
// result on a valid/ready output handshake.
// Optional feature macro: MATVEC3_CTRL_MREUSE_EN (adds keep_matrix so a
// finished job can skip straight to loading a new vector).
module matvec3_ctrl
  import matvec3_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic           clk,
  input  logic           reset,
  matvec3_ctrl_if.master bus
);

  localparam int MW = cnt_w(ROWS * COLS);
  localparam int XW = cnt_w(COLS);
  localparam int KW = cnt_w(COLS + 1);
  localparam int RW = cnt_w(ROWS);

  ctrl_state_t state_reg;
  ctrl_state_t state_next;
  logic        input_ready_reg;
  logic        output_valid_reg;
  logic        en_acc_reg;
  logic        clear_acc_reg;

  logic        accept;
  logic        out_hs;
  logic        job_done;
  logic        m_en;
  logic        x_en;
  logic        k_en;
  logic        r_en;

  logic [MW-1:0] m_cnt;
  logic          m_tc;
  logic [XW-1:0] x_cnt;
  logic          x_tc;
  logic [KW-1:0] k_cnt;
  logic          k_tc;
  logic [RW-1:0] r_cnt;
  logic          r_tc;

  logic [MW-1:0] mat_idx;
  logic [MW-1:0] addr_m_next;
  logic [XW-1:0] addr_x_next;

  // input_ready is only ever high in the load states, so an accepted beat
  // needs no further state qualification.
  assign accept   = bus.input_valid & input_ready_reg;
  assign out_hs   = (state_reg == OUTPUT) & bus.output_ready;
  assign job_done = out_hs & r_tc;

  assign m_en = accept & (state_reg == LOAD_M);
  assign x_en = accept & (state_reg == LOAD_X);
  // k runs 0..COLS and wraps to 0 on the step into OUTPUT, so it is
  // already 0 when the next row starts.
  assign k_en = (state_reg == COMPUTE);
  // r wraps to 0 on the last row's handshake, ready for the next job.
  assign r_en = out_hs;

  matvec3_cnt #(.MOD(ROWS * COLS)) u_m_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (m_en),
    .clr   (job_done),
    .count (m_cnt),
    .tc    (m_tc)
  );

  matvec3_cnt #(.MOD(COLS)) u_x_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (x_en),
    .clr   (job_done),
    .count (x_cnt),
    .tc    (x_tc)
  );

  matvec3_cnt #(.MOD(COLS + 1)) u_k_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (k_en),
    .clr   (job_done),
    .count (k_cnt),
    .tc    (k_tc)
  );

  matvec3_cnt #(.MOD(ROWS)) u_r_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (r_en),
    .clr   (job_done),
    .count (r_cnt),
    .tc    (r_tc)
  );

  // Next-state selection for the load / compute / output sequence.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      LOAD_M: begin
        if (accept && m_tc) state_next = LOAD_X;
      end
      LOAD_X: begin
        if (accept && x_tc) state_next = COMPUTE;
      end
      COMPUTE: begin
        if (k_tc) state_next = OUTPUT;
      end
      OUTPUT: begin
        if (bus.output_ready) begin
          if (!r_tc) begin
            state_next = COMPUTE;
          end else begin
`ifdef MATVEC3_CTRL_MREUSE_EN
            if (bus.keep_matrix) state_next = LOAD_X;
            else                 state_next = LOAD_M;
`else
            state_next = LOAD_M;
`endif
          end
        end
      end
      default: state_next = LOAD_M;
    endcase
  end

  // State register and registered handshake/accumulator strobes. The
  // accumulator strobes lag the read address by one cycle to cover the
  // memories' registered read: the product for k is added while k+1 is on
  // the address lines, and the k=0 product overwrites the accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= LOAD_M;
      input_ready_reg  <= 1'b0;
      output_valid_reg <= 1'b0;
      en_acc_reg       <= 1'b0;
      clear_acc_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      input_ready_reg  <= (state_next == LOAD_M) || (state_next == LOAD_X);
      output_valid_reg <= (state_next == OUTPUT);
      en_acc_reg       <= (state_reg == COMPUTE) && !k_tc;
      clear_acc_reg    <= (state_reg == COMPUTE) && (k_cnt == '0);
    end
  end

  // Row-major element index for the current row and column.
  always_comb begin
    mat_idx = MW'(int'(r_cnt) * COLS + int'(k_cnt));
  end

  // Address mux: load counters while loading, r/k while computing, and 0
  // otherwise so the k==COLS drain cycle never points past the array.
  always_comb begin
    addr_m_next = '0;
    addr_x_next = '0;
    unique case (state_reg)
      LOAD_M:  addr_m_next = m_cnt;
      LOAD_X:  addr_x_next = x_cnt;
      COMPUTE: begin
        if (!k_tc) begin
          addr_m_next = mat_idx;
          addr_x_next = XW'(k_cnt);
        end
      end
      default: begin
        addr_m_next = '0;
        addr_x_next = '0;
      end
    endcase
  end

  assign bus.input_ready  = input_ready_reg;
  assign bus.output_valid = output_valid_reg;
  assign bus.en_acc       = en_acc_reg;
  assign bus.clear_acc    = clear_acc_reg;
  assign bus.wr_en_m      = accept & (state_reg == LOAD_M);
  assign bus.wr_en_x      = accept & (state_reg == LOAD_X);
  assign bus.addr_m       = addr_m_next;
  assign bus.addr_x       = addr_x_next;

endmodule

// File: tb/tb_matvec3_ctrl.sv
// tb_matvec3_ctrl: drives matvec3_ctrl with randomized valid gaps and
// output stalls, attaches a behavioural datapath (memories with registered
// read, multiplier, accumulator) and compares every row result against a
// plain-arithmetic matrix-vector product. Define MATVEC3_CTRL_MREUSE_EN to
// also exercise the matrix-reuse path.
module tb_matvec3_ctrl;
  import matvec3_pkg::*;

  localparam int ROWS = DEF_ROWS;
  localparam int COLS = DEF_COLS;
  localparam int NM   = ROWS * COLS;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic signed [DATA_W-1:0] input_data = '0;

  matvec3_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  matvec3_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural datapath fed by the controller's strobes.
  logic signed [DATA_W-1:0] mem_m [NM];
  logic signed [DATA_W-1:0] mem_x [COLS];
  logic signed [DATA_W-1:0] rd_m;
  logic signed [DATA_W-1:0] rd_x;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  acc;

  assign prod = ACC_W'(rd_m) * ACC_W'(rd_x);

  always @(posedge clk) begin
    if (bus.wr_en_m) mem_m[bus.addr_m] <= input_data;
    if (bus.wr_en_x) mem_x[bus.addr_x] <= input_data;
    rd_m <= mem_m[bus.addr_m];
    rd_x <= mem_x[bus.addr_x];
    if (bus.en_acc) acc <= bus.clear_acc ? prod : acc + prod;
  end

  // Cycle monitor: clear_acc pulses and input_ready/output_valid overlap.
  int clr_total = 0;
  int both_bad  = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.clear_acc) clr_total++;
      if (bus.input_ready && bus.output_valid) both_bad++;
    end
  end

  // Reference model state.
  int cur_m [NM];
  int cur_x [COLS];
  int y_exp [ROWS];
  int clr_mark = 0;

  function automatic void ref_model();
    for (int r = 0; r < ROWS; r++) begin
      int s;
      s = 0;
      for (int c = 0; c < COLS; c++) s += cur_m[r*COLS + c] * cur_x[c];
      y_exp[r] = s;
    end
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < NM; i++)   cur_m[i] = int'($urandom_range(4000)) - 2000;
    for (int i = 0; i < COLS; i++) cur_x[i] = int'($urandom_range(4000)) - 2000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream one job's beats (matrix then vector, or vector only) with random gaps.
  task automatic load_job(input bit send_m);
    int n;
    n = send_m ? NM + COLS : COLS;
    for (int i = 0; i < n; i++) begin
      int  gap;
      int  w;
      int  idx;
      bit  is_m;
      gap  = int'($urandom_range(3));
      is_m = send_m && (i < NM);
      idx  = is_m ? i : (send_m ? i - NM : i);
      for (int g = 0; g < gap; g++) begin
        bus.input_valid = 1'b0;
        input_data = DATA_W'($urandom);
        #1;
        check_eq("gap_wr", longint'(bus.wr_en_m | bus.wr_en_x), 0);
        tick();
      end
      bus.input_valid = 1'b1;
      input_data = is_m ? DATA_W'(cur_m[idx]) : DATA_W'(cur_x[idx]);
      #1;
      w = 0;
      while (!bus.input_ready && w < 50) begin
        @(posedge clk);
        #2;
        w++;
      end
      if (w >= 50) check_eq("ready_timeout", 0, 1);
      if (is_m) begin
        check_eq("wr_en_m", longint'(bus.wr_en_m), 1);
        check_eq("addr_m", longint'(bus.addr_m), idx);
        check_eq("wr_en_x_idle", longint'(bus.wr_en_x), 0);
      end else begin
        check_eq("wr_en_x", longint'(bus.wr_en_x), 1);
        check_eq("addr_x", longint'(bus.addr_x), idx);
        check_eq("wr_en_m_idle", longint'(bus.wr_en_m), 0);
      end
      tick();
      bus.input_valid = 1'b0;
    end
  endtask

  // Wait for a row result, check latency, stall, then take it.
  task automatic check_row(input int r, input int stall, input bit keep);
    int w;
    longint snap;
    w = 0;
    while (!bus.output_valid && w < 60) begin
      tick();
      w++;
    end
    check_eq("latency", w, COLS + 1);
    bus.output_ready = 1'b0;
    snap = longint'(acc);
    for (int s = 0; s < stall; s++) begin
      tick();
      check_eq("hold_valid", longint'(bus.output_valid), 1);
      check_eq("hold_acc", longint'(acc), snap);
      check_eq("hold_en_acc", longint'(bus.en_acc), 0);
    end
`ifdef MATVEC3_CTRL_MREUSE_EN
    bus.keep_matrix = keep;
`else
    if (keep) w = 0;
`endif
    bus.output_ready = 1'b1;
    #1;
    check_eq($sformatf("row%0d_value", r), longint'(acc), y_exp[r]);
    check_eq("clear_per_row", clr_total - clr_mark, 1);
    clr_mark = clr_total;
    tick();
    bus.output_ready = 1'b0;
  endtask

  task automatic run_job(input bit send_m, input bit keep, input int hold_row);
    ref_model();
    load_job(send_m);
    for (int r = 0; r < ROWS; r++) begin
      check_row(r, (r == hold_row) ? 20 : int'($urandom_range(3)), keep && (r == ROWS - 1));
    end
    check_eq("ready_after_job", longint'(bus.input_ready), 1);
    check_eq("valid_after_job", longint'(bus.output_valid), 0);
    $display("job done: y = %0d %0d %0d", y_exp[0], y_exp[1], y_exp[2]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_ov;
    int seen_wr;
    int plan_m [NM]   = '{10, -20, 30, 50, -60, 70, 80, 100, -110};
    int plan_x [COLS] = '{40, 30, -20};

    bus.input_valid  = 1'b1;
    bus.output_ready = 1'b0;
`ifdef MATVEC3_CTRL_MREUSE_EN
    bus.keep_matrix  = 1'b0;
`endif
    input_data = DATA_W'(123);

    // Reset held with input_valid asserted: nothing may be accepted.
    repeat (3) begin
      tick();
      check_eq("rst_input_ready", longint'(bus.input_ready), 0);
      check_eq("rst_output_valid", longint'(bus.output_valid), 0);
      check_eq("rst_wr_en_m", longint'(bus.wr_en_m), 0);
      check_eq("rst_wr_en_x", longint'(bus.wr_en_x), 0);
      check_eq("rst_en_acc", longint'(bus.en_acc), 0);
      check_eq("rst_clear_acc", longint'(bus.clear_acc), 0);
      check_eq("rst_addr_m", longint'(bus.addr_m), 0);
      check_eq("rst_addr_x", longint'(bus.addr_x), 0);
    end
    #2 reset = 1'b0;
    #1;
    check_eq("rel_input_ready", longint'(bus.input_ready), 0);
    check_eq("rel_wr_en_m", longint'(bus.wr_en_m), 0);
    tick();
    check_eq("first_input_ready", longint'(bus.input_ready), 1);
    bus.input_valid = 1'b0;
    clr_mark = clr_total;

    // Directed job, with a 20-cycle output stall on row 1.
    cur_m = plan_m;
    cur_x = plan_x;
    run_job(1'b1, 1'b1, 1);

    // Idle: no new data, so no result and no writes.
    seen_ov = 0;
    seen_wr = 0;
    for (int i = 0; i < 100; i++) begin
      bus.input_valid = 1'b0;
      input_data = DATA_W'($urandom);
      #1;
      if (bus.output_valid) seen_ov++;
      if (bus.wr_en_m || bus.wr_en_x) seen_wr++;
      tick();
    end
    check_eq("idle_output_valid", seen_ov, 0);
    check_eq("idle_writes", seen_wr, 0);

`ifdef MATVEC3_CTRL_MREUSE_EN
    // Reuse the stored matrix: vector (1,0,0) selects its first column.
    cur_x = '{1, 0, 0};
    run_job(1'b0, 1'b0, -1);
`endif

    // Abort a job with reset while row 1 is being computed.
    fill_random();
    ref_model();
    load_job(1'b1);
    check_row(0, 1, 1'b0);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check_eq("abort_input_ready", longint'(bus.input_ready), 0);
    check_eq("abort_output_valid", longint'(bus.output_valid), 0);
    check_eq("abort_en_acc", longint'(bus.en_acc), 0);
    check_eq("abort_clear_acc", longint'(bus.clear_acc), 0);
    check_eq("abort_addr_m", longint'(bus.addr_m), 0);
    check_eq("abort_addr_x", longint'(bus.addr_x), 0);
    tick();
    #2 reset = 1'b0;
    #1;
    check_eq("abort_rel_ready", longint'(bus.input_ready), 0);
    tick();
    check_eq("abort_ready_up", longint'(bus.input_ready), 1);
    clr_mark = clr_total;

    // Fresh random jobs after the abort.
    for (int j = 0; j < 3; j++) begin
      fill_random();
      run_job(1'b1, 1'b0, -1);
    end

    check_eq("ready_valid_overlap", both_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
